// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory side of the pipeline's load/store port.
// A request (READ_WRITE[3]=1) is captured in IDLE, held for LATENCY cycles in
// ACCESS while BUSYWAIT stalls the pipeline, then completes with one DONE cycle.
// Storage is a word array with little-endian byte lanes.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned halfword/word
// accesses are flagged and suppressed instead of silently truncated).
module data_memory_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN_ERR
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [3:0] C_LB  = 4'b1000;
    localparam logic [3:0] C_LH  = 4'b1001;
    localparam logic [3:0] C_LW  = 4'b1010;
    localparam logic [3:0] C_SB  = 4'b1011;
    localparam logic [3:0] C_LBU = 4'b1100;
    localparam logic [3:0] C_LHU = 4'b1101;
    localparam logic [3:0] C_SH  = 4'b1110;
    localparam logic [3:0] C_SW  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             code_q, code_d;
    logic [ADDR_BITS+1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            mem_q [DEPTH];

    // Address bits above the array span only wrap; they are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:ADDR_BITS+2];

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    assign word_idx = addr_q[ADDR_BITS+1:2];
    assign lane     = addr_q[1:0];

    // Decode the latched access code into size, direction and extension.
    logic is_store, is_load, is_byte, is_half, is_signed;
    always_comb begin
        is_store  = (code_q == C_SB) || (code_q == C_SH) || (code_q == C_SW);
        is_load   = code_q[3] && !is_store;
        is_byte   = (code_q == C_LB) || (code_q == C_LBU) || (code_q == C_SB);
        is_half   = (code_q == C_LH) || (code_q == C_LHU) || (code_q == C_SH);
        is_signed = (code_q == C_LB) || (code_q == C_LH);
    end

    logic misalign;
`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (is_half && lane[0]) ||
                      ((code_q == C_LW || code_q == C_SW) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    logic finish;
    assign finish = (state_q == S_ACCESS) && (cnt_q == 4'd0);

    // Lane extraction for loads and lane merge for stores on the addressed word.
    logic [31:0] cur_word, load_val, merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    always_comb begin
        cur_word = mem_q[word_idx];
        byte_sel = cur_word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
        load_val = cur_word;
        if (is_byte)
            load_val = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
        else if (is_half)
            load_val = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
        merged = wdata_q;
        if (is_byte) begin
            merged = cur_word;
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end else if (is_half) begin
            merged = cur_word;
            if (lane[1]) merged[31:16] = wdata_q[15:0];
            else         merged[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state, request capture, counter and stall generation.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        BUSYWAIT = 1'b0;
        case (state_q)
            S_IDLE: begin
                BUSYWAIT = READ_WRITE[3];
                if (READ_WRITE[3]) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                    code_d  = READ_WRITE;
                    addr_d  = ADDRESS[ADDR_BITS+1:0];
                    wdata_d = WRITE_DATA;
                end
            end
            S_ACCESS: begin
                BUSYWAIT = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (is_load && !misalign) rdata_d = load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            code_q  <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array write port; commits a store on the final ACCESS edge.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset so it maps onto plain RAM; a reset aborts the store via state_q instead.
        if (finish && is_store && !misalign) mem_q[word_idx] <= merged;
    end

    assign READ_DATA    = rdata_q;
    assign MISALIGN_ERR = (state_q == S_DONE) && misalign;

endmodule
